mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one N-bit `multiplier` instance (low-half product plus Z/N/C/V flags) among REQS requesters, e.g. the scalar ALU and the vector-lane ALUs.
- Accepts one operation per cycle through a round-robin arbiter with valid/ready handshakes.
- Carries each operation through a LAT-stage registered pipeline with a requester tag.
- Returns results on a single response bus with consumer backpressure.

Parameters:
N, 24, operand/result width passed to the multiplier
REQS, 2, number of requesters (>=2)
LAT, 2, pipeline depth in registered stages (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  REQS  per-requester operation request
req_ready  output  REQS  per-requester accept; handshake when req_valid[i]&req_ready[i]
req_a  input  REQS*N  operand A, requester i at bits [i*N +: N]
req_b  input  REQS*N  operand B, same packing
resp_valid  output  1  response bus holds a result
resp_ready  input  1  consumer accepts the result
resp_id  output  $clog2(REQS)  index of the requester that issued the result
resp_result  output  N  product bits [N-1:0]
resp_z  output  1  zero flag
resp_n  output  1  negative flag
resp_c  output  1  carry flag
resp_v  output  1  overflow flag
idle  output  1  no operation in flight

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits clear; resp_valid=0, req_ready=0, idle=1; round-robin pointer=0; resp_id/result/flags=0. Operations in flight are discarded and never reported.
- advance = !resp_valid | resp_ready. When advance=0 the whole pipeline holds, resp_* outputs stay stable, and all req_ready are 0.
- Arbitration (combinational):
  - grant goes to the first i with req_valid[i], searching from pointer and wrapping.
  - req_ready[i] = grant[i] & advance; at most one req_ready bit is high.
  - req_ready never depends on req_valid of the same requester being held across cycles; requests may drop without a handshake.
- Pointer moves to (granted index+1) mod REQS only on a completed handshake; otherwise it holds.
- Stage 1 registers a, b and id on handshake. Its valid bit is written every advance edge (1 on handshake, 0 otherwise), so bubbles propagate.
- The multiplier evaluates the stage-1 operands combinationally. Stages 2..LAT register result, flags and id; stage LAT drives the resp_* outputs.
- Latency: a request accepted in cycle c appears on resp_* in cycle c+LAT, absent stalls. Each stall cycle adds exactly one cycle.
- Throughput: one operation per cycle with resp_ready held high.
- Flag rules, with r = a*b as an unsigned 2N-bit product:
  - result = r[N-1:0]
  - z = (result==0)
  - c = |r[2N-2:N] (r[2N-1] excluded)
  - n = r[N-1]
  - v = (a[N-1] ~^ b[N-1]) & n
- Simultaneous events:
  - A handshake and a response consumption in the same cycle both take effect.
  - A request arriving at the same edge the stall releases is accepted on that edge.
- idle = no stage valid bit set.

Test Plan:
- Single op, N=24: requester 0 sends a=3, b=5; resp_ready=1 -> resp_valid in cycle c+2, resp_id=0, result=15, z=n=c=v=0, idle returns to 1 the next cycle.
- Flags: a=0x400000, b=2 -> result=0x800000, n=1, v=1, c=0, z=0. Then a=0x001000, b=0x001000 -> result=0, z=1, c=1, n=0, v=0.
- Round-robin: both requesters hold req_valid for 6 cycles with distinct operands -> grants alternate 0,1,0,1,0,1. Responses arrive back-to-back, in order, with matching resp_id and products.
- Backpressure: resp_ready=0 for 3 cycles while a result is on the bus -> resp_* stable, req_ready=0, pointer unchanged. On release, the held result is consumed and the pipeline shifts with no loss or duplication.
- Bubbles: requests with one idle cycle between them -> resp_valid shows the matching gap, and no stale data is reported.
- Reset mid-op: assert rst with 2 ops in flight and resp_ready=0 -> resp_valid drops immediately without waiting for clk, idle=1. After release, the first request goes to requester 0 when both are valid.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester and response bus bundle for mul_arbiter
interface mul_arbiter_if #(
  parameter int N    = 24,
  parameter int REQS = 2
);
  localparam int IDW = $clog2(REQS);

  logic [REQS-1:0]   req_valid;
  logic [REQS-1:0]   req_ready;
  logic [REQS*N-1:0] req_a;
  logic [REQS*N-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [N-1:0]      resp_result;
  logic              resp_z;
  logic              resp_n;
  logic              resp_c;
  logic              resp_v;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result,
    input  resp_z, resp_n, resp_c, resp_v
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result,
    output resp_z, resp_n, resp_c, resp_v
  );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin shared multiplier with tagged LAT-stage pipeline
module mul_arbiter #(
  parameter int N    = 24,
  parameter int REQS = 2,
  parameter int LAT  = 2
) (
  input  logic           clk,
  input  logic           rst,
  mul_arbiter_if.slave   bus,
  output logic           idle
);
  localparam int IDW = $clog2(REQS);

  logic            advance;
  logic            hs;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [REQS-1:0] grant;
  logic [IDW-1:0]  ptr;

  logic            s1_valid;
  logic [N-1:0]    s1_a;
  logic [N-1:0]    s1_b;
  logic [IDW-1:0]  s1_id;

  logic [2*N-1:0]  prod;
  logic [N-1:0]    m_result;
  logic [3:0]      m_flags;

  logic            st_valid  [2:LAT];
  logic [N-1:0]    st_result [2:LAT];
  logic [3:0]      st_flags  [2:LAT];
  logic [IDW-1:0]  st_id     [2:LAT];

  assign advance = !st_valid[LAT] | bus.resp_ready;

  // Descending scan so the last hit is the closest requester at or after ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int i = REQS - 1; i >= 0; i--) begin
      if (bus.req_valid[(int'(ptr) + i) % REQS]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((int'(ptr) + i) % REQS);
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = rst ? (grant & {REQS{advance}}) : '0;
  assign hs            = rst & advance & gnt_any;

  assign prod     = {{N{1'b0}}, s1_a} * {{N{1'b0}}, s1_b};
  assign m_result = prod[N-1:0];
  // Flags packed as {z, n, c, v}; the top product bit is deliberately left out of carry.
  assign m_flags  = {(m_result == '0),
                     prod[N-1],
                     |prod[2*N-2:N],
                     (s1_a[N-1] ~^ s1_b[N-1]) & prod[N-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      for (int k = 2; k <= LAT; k++) begin
        st_valid[k]  <= 1'b0;
        st_result[k] <= '0;
        st_flags[k]  <= '0;
        st_id[k]     <= '0;
      end
    end else if (advance) begin
      s1_valid <= hs;
      if (hs) begin
        s1_a  <= bus.req_a[gnt_idx*N +: N];
        s1_b  <= bus.req_b[gnt_idx*N +: N];
        s1_id <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(REQS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      st_valid[2]  <= s1_valid;
      st_result[2] <= m_result;
      st_flags[2]  <= m_flags;
      st_id[2]     <= s1_id;
      for (int k = 3; k <= LAT; k++) begin
        st_valid[k]  <= st_valid[k-1];
        st_result[k] <= st_result[k-1];
        st_flags[k]  <= st_flags[k-1];
        st_id[k]     <= st_id[k-1];
      end
    end
  end

  always_comb begin
    idle = !s1_valid;
    for (int k = 2; k <= LAT; k++) begin
      if (st_valid[k]) idle = 1'b0;
    end
  end

  assign bus.resp_valid  = st_valid[LAT];
  assign bus.resp_id     = st_id[LAT];
  assign bus.resp_result = st_result[LAT];
  assign bus.resp_z      = st_flags[LAT][3];
  assign bus.resp_n      = st_flags[LAT][2];
  assign bus.resp_c      = st_flags[LAT][1];
  assign bus.resp_v      = st_flags[LAT][0];
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed self-checking bench for mul_arbiter
module tb_mul_arbiter;
  logic clk;
  logic rst;
  logic idle;
  int   n_checks;
  int   n_fail;

  mul_arbiter_if #(.N(24), .REQS(2)) ifc ();

  mul_arbiter #(.N(24), .REQS(2), .LAT(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc),
    .idle (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [23:0] res, input logic id,
                          input logic [3:0] flags);
    chk({tag, "_valid"}, 64'(ifc.resp_valid), 64'(1));
    chk({tag, "_id"}, 64'(ifc.resp_id), 64'(id));
    chk({tag, "_result"}, 64'(ifc.resp_result), 64'(res));
    chk({tag, "_flags"}, 64'({ifc.resp_z, ifc.resp_n, ifc.resp_c, ifc.resp_v}), 64'(flags));
  endtask

  task automatic drive(input logic [1:0] v, input logic [23:0] a0, input logic [23:0] b0,
                       input logic [23:0] a1, input logic [23:0] b1);
    ifc.req_valid = v;
    ifc.req_a     = {a1, a0};
    ifc.req_b     = {b1, b0};
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [23:0] rr_prod [6];
  logic        rr_id   [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rr_prod  = '{24'd30, 24'd147, 24'd36, 24'd161, 24'd42, 24'd175};
    rr_id    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    ifc.resp_ready = 1'b1;
    drive(2'b11, 24'd1, 24'd1, 24'd1, 24'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_resp_valid", 64'(ifc.resp_valid), 64'(0));
    chk("rst_req_ready", 64'(ifc.req_ready), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_resp_id", 64'(ifc.resp_id), 64'(0));
    chk("rst_resp_result", 64'(ifc.resp_result), 64'(0));
    rst = 1'b1;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    step;

    // single op 3*5
    drive(2'b01, 24'd3, 24'd5, 24'd0, 24'd0);
    #1 chk("single_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk("single_c1_valid", 64'(ifc.resp_valid), 64'(0));
    chk("single_c1_idle", 64'(idle), 64'(0));
    step;
    #1 chk_resp("single", 24'd15, 1'b0, 4'b0000);
    step;
    #1 chk("single_c3_valid", 64'(ifc.resp_valid), 64'(0));
    chk("single_c3_idle", 64'(idle), 64'(1));

    // flags: pointer is 1, requester 0 wins by wrap, then requester 1
    drive(2'b01, 24'h400000, 24'd2, 24'd0, 24'd0);
    #1 chk("flags0_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b10, 24'd0, 24'd0, 24'h001000, 24'h001000);
    #1 chk("flags1_ready", 64'(ifc.req_ready), 64'(2'b10));
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk_resp("flags_neg", 24'h800000, 1'b0, 4'b0101);
    step;
    #1 chk_resp("flags_zero", 24'h000000, 1'b1, 4'b1010);
    step;

    // round robin, both requesters valid for 6 cycles
    for (int k = 0; k < 8; k++) begin
      if (k < 6) drive(2'b11, 24'(10 + k), 24'd3, 24'(20 + k), 24'd7);
      else       drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
      #1;
      if (k < 6) chk("rr_ready", 64'(ifc.req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      if (k >= 2) chk_resp("rr", rr_prod[k-2], rr_id[k-2], 4'b0000);
      step;
    end
    #1 chk("rr_tail_valid", 64'(ifc.resp_valid), 64'(0));

    // backpressure: 3 stall cycles with a result on the bus
    drive(2'b01, 24'd6, 24'd7, 24'd0, 24'd0);
    #1 chk("bp_a_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b10, 24'd0, 24'd0, 24'd8, 24'd9);
    #1 chk("bp_b_ready", 64'(ifc.req_ready), 64'(2'b10));
    step;
    ifc.resp_ready = 1'b0;
    drive(2'b11, 24'd2, 24'd50, 24'd3, 24'd3);
    for (int k = 0; k < 3; k++) begin
      #1 chk_resp("bp_hold", 24'd42, 1'b0, 4'b0000);
      chk("bp_hold_ready", 64'(ifc.req_ready), 64'(2'b00));
      step;
    end
    ifc.resp_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(ifc.req_ready), 64'(2'b01));
    chk_resp("bp_release", 24'd42, 1'b0, 4'b0000);
    step;
    drive(2'b10, 24'd0, 24'd0, 24'd3, 24'd3);
    #1 chk("bp_next_ready", 64'(ifc.req_ready), 64'(2'b10));
    chk_resp("bp_b", 24'd72, 1'b1, 4'b0000);
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk_resp("bp_c", 24'd100, 1'b0, 4'b0000);
    step;
    #1 chk_resp("bp_d", 24'd9, 1'b1, 4'b0000);
    step;
    #1 chk("bp_end_valid", 64'(ifc.resp_valid), 64'(0));
    chk("bp_end_idle", 64'(idle), 64'(1));

    // bubbles between requests
    drive(2'b01, 24'd4, 24'd4, 24'd0, 24'd0);
    #1 chk("bub_a_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk("bub_c1_valid", 64'(ifc.resp_valid), 64'(0));
    step;
    drive(2'b01, 24'd5, 24'd5, 24'd0, 24'd0);
    #1 chk("bub_b_ready", 64'(ifc.req_ready), 64'(2'b01));
    chk_resp("bub_a", 24'd16, 1'b0, 4'b0000);
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk("bub_gap_valid", 64'(ifc.resp_valid), 64'(0));
    step;
    #1 chk_resp("bub_b", 24'd25, 1'b0, 4'b0000);
    step;
    #1 chk("bub_end_valid", 64'(ifc.resp_valid), 64'(0));
    chk("bub_end_idle", 64'(idle), 64'(1));

    // reset with two ops in flight and the consumer stalled
    ifc.resp_ready = 1'b0;
    drive(2'b01, 24'd7, 24'd7, 24'd0, 24'd0);
    #1 chk("rmid_a_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b01, 24'd8, 24'd8, 24'd0, 24'd0);
    #1 chk("rmid_b_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk_resp("rmid_before", 24'd49, 1'b0, 4'b0000);
    chk("rmid_before_idle", 64'(idle), 64'(0));
    #2 rst = 1'b0;
    #1 chk("rmid_async_valid", 64'(ifc.resp_valid), 64'(0));
    chk("rmid_async_idle", 64'(idle), 64'(1));
    chk("rmid_async_result", 64'(ifc.resp_result), 64'(0));
    step;
    rst = 1'b1;
    ifc.resp_ready = 1'b1;
    drive(2'b11, 24'd9, 24'd9, 24'd1, 24'd1);
    #1 chk("rmid_after_ready", 64'(ifc.req_ready), 64'(2'b01));
    step;
    drive(2'b00, 24'd0, 24'd0, 24'd0, 24'd0);
    #1 chk("rmid_no_stale", 64'(ifc.resp_valid), 64'(0));
    step;
    #1 chk_resp("rmid_after", 24'd81, 1'b0, 4'b0000);
    step;
    #1 chk("rmid_end_valid", 64'(ifc.resp_valid), 64'(0));
    chk("rmid_end_idle", 64'(idle), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
